// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encodings and
// the occupancy states of the output/skid register pair.
package imm_ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SEXT    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ZEXT    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SEXT_LO = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ZEXT_LO = 3'd4;

    // Encoded as {main_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> (data, err).
// Shared with the branch-offset path, so it carries no state.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  data,
    output logic              err
);

    localparam int H = IN_W / 2;

    logic signed [IN_W-1:0] imm_s;
    logic signed [H-1:0]    lo_s;
    logic        [H-1:0]    lo_u;

    assign imm_s = imm;
    assign lo_u  = imm[H-1:0];
    assign lo_s  = lo_u;

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            MODE_SEXT:    data = OUT_W'(imm_s);
            MODE_ZEXT:    data = OUT_W'(imm);
            // Shift of zero when OUT_W == IN_W makes UPPER identical to ZEXT.
            MODE_UPPER:   data = OUT_W'(imm) << (OUT_W - IN_W);
            MODE_SEXT_LO: data = OUT_W'(lo_s);
            MODE_ZEXT_LO: data = OUT_W'(lo_u);
            default:      err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate extension with a valid/ready handshake, a one-entry
// skid buffer for backpressure, an illegal-mode flag and a delivery counter.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  out_count
);

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data),
        .err  (ext_err)
    );

    logic             main_valid_q, main_valid_d;
    logic [OUT_W-1:0] main_data_q,  main_data_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             main_err_q,   main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_err_q,   skid_err_d;
    logic             in_ready_q,   in_ready_d;
    logic [CNT_W-1:0] count_q,      count_d;

    logic in_xfer;
    logic out_xfer;
    occ_e occ;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = main_valid_q && out_ready;
    assign occ      = occ_e'({main_valid_q, skid_valid_q});

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        count_d      = count_q;

        case (occ)
            OCC_EMPTY: begin
                if (in_xfer) begin
                    main_valid_d = 1'b1;
                    main_data_d  = ext_data;
                    main_tag_d   = in_tag;
                    main_err_d   = ext_err;
                end
            end
            OCC_ONE: begin
                if (out_xfer && in_xfer) begin
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                    main_err_d  = ext_err;
                end else if (out_xfer) begin
                    main_valid_d = 1'b0;
                end else if (in_xfer) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = ext_data;
                    skid_tag_d   = in_tag;
                    skid_err_d   = ext_err;
                end
            end
            OCC_FULL: begin
                if (out_xfer) begin
                    main_data_d  = skid_data_q;
                    main_tag_d   = skid_tag_q;
                    main_err_d   = skid_err_q;
                    skid_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (out_xfer) begin
            count_d = count_q + 1'b1;
        end

        // Registered ready: mirrors the skid occupancy after this edge, so it
        // never depends combinationally on out_ready.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;
    assign out_count = count_q;

endmodule
